// File: rtl/resp_pkg.sv
// Shared types for the BCD request/acknowledge responder: operand type,
// BCD limit and the response pipeline slot.
package resp_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  typedef struct packed {
    logic valid;
    logic is_nack;
    bcd_t data;
    logic carry;
  } rsp_slot_t;

endpackage

// File: rtl/bcd_acc_step.sv
// One BCD accumulate step: adds an operand to the accumulator modulo 10 and
// flags decimal carry; operands above 9 are reported invalid and leave acc alone.
module bcd_acc_step
  import resp_pkg::*;
(
  input  logic [3:0] acc,
  input  logic [3:0] operand,
  output logic [3:0] next_acc,
  output logic       carry,
  output logic       invalid
);

  logic [4:0] sum;

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    next_acc = acc;
    carry    = 1'b0;
    invalid  = (operand > BCD_MAX);
    sum      = {1'b0, acc} + {1'b0, operand};
    if (!invalid) begin
      if (sum >= 5'd10) begin
        carry    = 1'b1;
        next_acc = 4'(sum - 5'd10);
      end else begin
        next_acc = sum[3:0];
      end
    end
  end

endmodule

// File: rtl/req_ack_responder.sv
// BCD accumulating responder: every request is answered with ack or nack
// exactly ACK_LAT (1 or 2) cycles later. Define RESP_SVA_EN to embed assertions.
module req_ack_responder
  import resp_pkg::*;
#(
  parameter int ACK_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [3:0] req_data,
  input  logic       clear,
  output logic       ack,
  output logic       nack,
  output logic [3:0] rsp_data,
  output logic       rsp_carry,
  output logic [7:0] carry_cnt
);

  bcd_t      acc;
  bcd_t      acc_base;
  bcd_t      step_acc;
  logic      step_carry;
  logic      step_invalid;
  rsp_slot_t slot_in;
  rsp_slot_t pipe [ACK_LAT];
  rsp_slot_t last;

  // clear takes effect before a coincident request is added
  assign acc_base = clear ? '0 : acc;

  bcd_acc_step u_step (
    .acc      (acc_base),
    .operand  (req_data),
    .next_acc (step_acc),
    .carry    (step_carry),
    .invalid  (step_invalid)
  );

  always_comb begin
    slot_in = '0;
    if (req) begin
      slot_in.valid   = 1'b1;
      slot_in.is_nack = step_invalid;
      slot_in.data    = step_acc;
      slot_in.carry   = step_carry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so the shift register
  // moves one stage per edge regardless of statement order.
  // NOTE: the pipeline is a few flops, so every slot is reset; this is what
  // drops in-flight requests when reset hits mid-operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      carry_cnt <= '0;
      for (int i = 0; i < ACK_LAT; i++) pipe[i] <= '0;
    end else begin
      acc       <= req ? step_acc : acc_base;
      carry_cnt <= (clear ? 8'd0 : carry_cnt) + {7'd0, req & step_carry};
      pipe[0]   <= slot_in;
      for (int i = 1; i < ACK_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign last      = pipe[ACK_LAT-1];
  assign ack       = last.valid & ~last.is_nack;
  assign nack      = last.valid & last.is_nack;
  assign rsp_data  = last.data;
  assign rsp_carry = last.carry;

`ifdef RESP_SVA_EN
  a_latency : assert property (@(posedge clk) disable iff (!rst_n)
    req |-> ##ACK_LAT (ack || nack));

  a_mutex : assert property (@(posedge clk) disable iff (!rst_n)
    !(ack && nack));

  a_acc_range : assert property (@(posedge clk) disable iff (!rst_n)
    acc <= BCD_MAX);

  a_clear_cnt : assert property (@(posedge clk) disable iff (!rst_n)
    ($rose(clear) && !(req && step_carry)) |=> (carry_cnt == 8'd0));
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Self-checking bench: ACK_LAT=1 and ACK_LAT=2 instances share stimulus and are
// compared against an arithmetic model of the decimal accumulator.
module tb_req_ack_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [3:0] req_data = '0;
  logic       clear = 1'b0;

  logic       ack1, nack1, rsp_carry1, ack2, nack2, rsp_carry2;
  logic [3:0] rsp_data1, rsp_data2;
  logic [7:0] carry_cnt1, carry_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  req_ack_responder #(.ACK_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .clear(clear),
    .ack(ack1), .nack(nack1), .rsp_data(rsp_data1), .rsp_carry(rsp_carry1),
    .carry_cnt(carry_cnt1)
  );

  req_ack_responder #(.ACK_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .clear(clear),
    .ack(ack2), .nack(nack2), .rsp_data(rsp_data2), .rsp_carry(rsp_carry2),
    .carry_cnt(carry_cnt2)
  );

  typedef struct {
    bit v;
    bit n;
    int d;
    bit c;
  } exp_t;

  int   m_acc;
  int   m_cnt;
  exp_t hist [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_acc = 0;
    m_cnt = 0;
    hist[0] = '{0, 0, 0, 0};
    hist[1] = '{0, 0, 0, 0};
  endfunction

  // Decimal accumulator behaviour evaluated from the sampled inputs of one edge.
  function automatic void model_edge(input bit r, input int d, input bit clr);
    exp_t e;
    int   s;
    e = '{0, 0, 0, 0};
    if (clr) begin
      m_acc = 0;
      m_cnt = 0;
    end
    if (r) begin
      e.v = 1;
      if (d > 9) begin
        e.n = 1;
        e.d = m_acc;
      end else begin
        s     = m_acc + d;
        m_acc = s % 10;
        e.d   = m_acc;
        e.c   = (s >= 10);
        if (e.c) m_cnt = (m_cnt + 1) % 256;
      end
    end
    hist[1] = hist[0];
    hist[0] = e;
  endfunction

  task automatic check_outputs();
    check("ack_l1",  ack1,  hist[0].v && !hist[0].n);
    check("nack_l1", nack1, hist[0].v &&  hist[0].n);
    if (hist[0].v) begin
      check("data_l1",  rsp_data1,  hist[0].d);
      check("carry_l1", rsp_carry1, hist[0].c);
    end
    check("ack_l2",  ack2,  hist[1].v && !hist[1].n);
    check("nack_l2", nack2, hist[1].v &&  hist[1].n);
    if (hist[1].v) begin
      check("data_l2",  rsp_data2,  hist[1].d);
      check("carry_l2", rsp_carry2, hist[1].c);
    end
    check("cnt_l1", carry_cnt1, m_cnt);
    check("cnt_l2", carry_cnt2, m_cnt);
  endtask

  task automatic step(input bit r, input int d, input bit clr);
    req      = r;
    req_data = 4'(d);
    clear    = clr;
    @(posedge clk);
    model_edge(r, d, clr);
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},  {ack1, ack2, nack1, nack2}, 0);
    check({tag, "_data"}, {rsp_data1, rsp_data2, rsp_carry1, rsp_carry2}, 0);
    check({tag, "_cnt"},  {carry_cnt1, carry_cnt2}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // 7 then 5 back-to-back from acc=0
    step(1, 7, 0);
    step(1, 5, 0);
    step(0, 0, 0);
    check("seq75_cnt", carry_cnt1, 1);
    step(0, 0, 0);

    // single 9 on the two-cycle instance with idle cycle in between
    do_reset();
    step(1, 9, 0);
    check("lat2_gap", {ack2, nack2}, 0);
    step(0, 0, 0);
    check("lat2_data", rsp_data2, 9);
    step(0, 0, 0);

    // invalid operand while acc=4
    do_reset();
    step(1, 4, 0);
    step(1, 12, 0);
    check("nack_data", rsp_data1, 4);
    step(1, 0, 0);
    check("acc_kept", rsp_data1, 4);
    step(0, 0, 0);

    // build acc=8, carry_cnt=5, then clear with a coincident req of 3
    do_reset();
    repeat (6) step(1, 9, 0);
    step(1, 4, 0);
    check("pre_clear_cnt", carry_cnt1, 5);
    step(1, 3, 1);
    check("clear_data", rsp_data1, 3);
    check("clear_cnt", carry_cnt1, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // reset one cycle after a request drops it
    do_reset();
    step(1, 9, 0);
    req = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all_zero("midrst_now");
    @(posedge clk);
    #1 check_all_zero("midrst_edge");
    rst_n = 1'b1;
    repeat (3) step(0, 0, 0);

    // 260 carries wrap the counter to 4
    do_reset();
    step(1, 1, 0);
    for (int i = 0; i < 260; i++) begin
      step(1, 9, 0);
      step(1, 1, 0);
    end
    check("wrap_cnt", carry_cnt1, 4);
    step(0, 0, 0);

    // randomized traffic with occasional clear
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 15)),
           $urandom_range(0, 9) == 0);
    end
    repeat (2) step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
